// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer: drives inst_reg, sequences register reads,
// ALU operands/opcode and write-back, and handles JMP/JNZ/HLT.
module ctrl_seq #(
    parameter int PC_W     = 8,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   pc,
    output logic              ir_en,
    input  logic [15:0]       ir_data,
    output logic [1:0]        reg_addr,
    output logic              reg_rd,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic              halted,
    output logic              retire
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_RD1    = 3'd3;
    localparam logic [2:0] ST_RD2    = 3'd4;
    localparam logic [2:0] ST_EXEC   = 3'd5;
    localparam logic [2:0] ST_WB     = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    localparam logic [3:0] OP_INV  = 4'b0101;
    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_DEC  = 4'b1011;
    localparam logic [3:0] OP_HLT  = 4'b1100;
    localparam logic [3:0] OP_JNZ  = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        dst_q, dst_d;
    logic [7:0]        imm_q, imm_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;

    // Bits 11:10 of the instruction word carry no field.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_data[11:10];

    function automatic logic is_two_op(input logic [3:0] op);
        return (op <= 4'b0100);
    endfunction

    function automatic logic needs_read(input logic [3:0] op);
        return is_two_op(op) || (op == OP_INV) || (op == OP_INC) ||
               (op == OP_DEC) || (op == OP_JNZ);
    endfunction

    logic [3:0]      dec_op;
    logic [1:0]      s1, s2;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] dec_target;
    logic [PC_W-1:0] q_target;

    assign dec_op     = ir_data[15:12];
    assign s1         = imm_q[5:4];
    assign s2         = imm_q[1:0];
    assign pc_inc     = pc_q + PC_W'(1);
    assign dec_target = PC_W'(ir_data[7:0]);
    assign q_target   = PC_W'(imm_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        ir_en     = 1'b0;
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = 2'd0;
        reg_wdata = '0;
        halted    = 1'b0;
        retire    = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                ir_en   = 1'b1;
                state_d = ST_DECODE;
            end

            // Branch/halt decisions use ir_data directly; the IR copy is for later states.
            ST_DECODE: begin
                op_d  = dec_op;
                dst_d = ir_data[9:8];
                imm_d = ir_data[7:0];
                if (needs_read(dec_op)) begin
                    state_d = ST_RD1;
                end else if (dec_op == OP_LOAD) begin
                    state_d = ST_WB;
                end else if (dec_op == OP_JMP) begin
                    pc_d    = dec_target;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (dec_op == OP_HLT) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_RD1: begin
                reg_rd   = 1'b1;
                reg_addr = (is_two_op(op_q) || (op_q == OP_INV)) ? s1 : dst_q;
                state_d  = ST_RD2;
            end

            ST_RD2: begin
                alu_a_d = reg_rdata;
                if (is_two_op(op_q)) begin
                    reg_rd   = 1'b1;
                    reg_addr = s2;
                    state_d  = ST_EXEC;
                end else if ((op_q == OP_INC) || (op_q == OP_DEC)) begin
                    alu_b_d = DATA_W'(1);
                    state_d = ST_EXEC;
                end else if (op_q == OP_JNZ) begin
                    pc_d    = (reg_rdata != '0) ? q_target : pc_inc;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (is_two_op(op_q)) begin
                    alu_b_d = reg_rdata;
                end
                if (op_q == OP_INC) begin
                    alu_op_d = 3'b000;
                end else if (op_q == OP_DEC) begin
                    alu_op_d = 3'b001;
                end else begin
                    alu_op_d = op_q[2:0];
                end
                state_d = ST_WB;
            end

            ST_WB: begin
                reg_wr    = 1'b1;
                reg_addr  = dst_q;
                reg_wdata = (op_q == OP_LOAD) ? DATA_W'(imm_q) : alu_out;
                pc_d      = pc_inc;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC_W'(RESET_PC);
            op_q     <= 4'd0;
            dst_q    <= 2'd0;
            imm_q    <= 8'd0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            imm_q    <= imm_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign pc     = pc_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule
